// File: rtl/stg_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stg_wb_pkg
// Purpose : Shared sizes and opcodes for the amber write-back stage.
// Revision: 1.0 - initial release
// ============================================================================
package stg_wb_pkg;

  localparam int SIZE_DATA   = 24;
  localparam int SIZE_ADDR   = 24;
  localparam int SIZE_OPC    = 5;
  localparam int SIZE_TGT_GP = 4;
  localparam int SIZE_TGT_SR = 2;

  localparam logic [SIZE_OPC-1:0] OPC_NOP = 5'h00;
  localparam logic [SIZE_OPC-1:0] OPC_HLT = 5'h1F;

  // Every opcode except NOP counts as a retired instruction, HLT included.
  function automatic logic opc_retires(input logic [SIZE_OPC-1:0] opc);
    return opc != OPC_NOP;
  endfunction

endpackage : stg_wb_pkg
`default_nettype wire

// File: rtl/stg_wb_regfile_bypass.sv
`default_nettype none
// ============================================================================
// Module  : stg_wb_regfile_bypass
// Purpose : Register file, single write port, NRD combinational read ports
//           with same-cycle write-through bypass.
// Revision: 1.0 - initial release
// ============================================================================
module stg_wb_regfile_bypass #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 24,
  parameter int NRD    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [NRD-1:0][IDX_W-1:0]     rd_idx,
  output logic [NRD-1:0][DATA_W-1:0]    rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic              wr_valid;

  // Indices beyond DEPTH match no entry, so such writes vanish and reads give 0.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign wr_hit[gi] = we && (wr_idx == IDX_W'(gi));
  end

  assign wr_valid = |wr_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wr_hit[e]) mem[e] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (rd_idx[p] == IDX_W'(e)) rd_data[p] = mem[e];
      end
      if (wr_valid && (rd_idx[p] == wr_idx)) rd_data[p] = wr_data;
    end
  end

endmodule : stg_wb_regfile_bypass
`default_nettype wire

// File: rtl/stg_wb.sv
`default_nettype none
// ============================================================================
// Module  : stg_wb
// Purpose : Amber stage 6 (write-back): GP/SR register files, halt state
//           and retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
module stg_wb
  import stg_wb_pkg::*;
#(
  parameter int NUM_GP = 16,
  parameter int NUM_SR = 4,
  parameter int RET_W  = 32
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst_n,
  input  logic [SIZE_ADDR-1:0]   iw_pc,
  input  logic [SIZE_DATA-1:0]   iw_instr,
  input  logic [SIZE_OPC-1:0]    iw_opc,
  input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic                   iw_tgt_gp_we,
  input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic                   iw_tgt_sr_we,
  input  logic [SIZE_DATA-1:0]   iw_result,
  input  logic [SIZE_TGT_GP-1:0] iw_rd_gp_a,
  output logic [SIZE_DATA-1:0]   ow_rd_gp_a,
  input  logic [SIZE_TGT_GP-1:0] iw_rd_gp_b,
  output logic [SIZE_DATA-1:0]   ow_rd_gp_b,
  input  logic [SIZE_TGT_SR-1:0] iw_rd_sr,
  output logic [SIZE_DATA-1:0]   ow_rd_sr,
  output logic [RET_W-1:0]       ow_retired,
  output logic                   ow_halted,
  output logic [SIZE_ADDR-1:0]   ow_halt_pc
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  wb_state_e state;
  logic      run;
  logic      gp_we;
  logic      sr_we;

  logic [1:0][SIZE_DATA-1:0] gp_rd;
  logic [0:0][SIZE_DATA-1:0] sr_rd;

  // The raw instruction word is carried for debug visibility only.
  logic unused_instr;
  assign unused_instr = ^iw_instr;

  // Gating the enables here also disables bypass once halted.
  assign run   = (state == ST_RUN);
  assign gp_we = run && iw_tgt_gp_we;
  assign sr_we = run && iw_tgt_sr_we;

  stg_wb_regfile_bypass #(
    .DEPTH  (NUM_GP),
    .IDX_W  (SIZE_TGT_GP),
    .DATA_W (SIZE_DATA),
    .NRD    (2)
  ) u_gp (
    .clk     (iw_clk),
    .rst_n   (iw_rst_n),
    .we      (gp_we),
    .wr_idx  (iw_tgt_gp),
    .wr_data (iw_result),
    .rd_idx  ({iw_rd_gp_b, iw_rd_gp_a}),
    .rd_data (gp_rd)
  );

  stg_wb_regfile_bypass #(
    .DEPTH  (NUM_SR),
    .IDX_W  (SIZE_TGT_SR),
    .DATA_W (SIZE_DATA),
    .NRD    (1)
  ) u_sr (
    .clk     (iw_clk),
    .rst_n   (iw_rst_n),
    .we      (sr_we),
    .wr_idx  (iw_tgt_sr),
    .wr_data (iw_result),
    .rd_idx  (iw_rd_sr),
    .rd_data (sr_rd)
  );

  assign ow_rd_gp_a = gp_rd[0];
  assign ow_rd_gp_b = gp_rd[1];
  assign ow_rd_sr   = sr_rd[0];

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state      <= ST_RUN;
      ow_halted  <= 1'b0;
      ow_halt_pc <= '0;
      ow_retired <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (opc_retires(iw_opc)) ow_retired <= ow_retired + RET_W'(1);
          if (iw_opc == OPC_HLT) begin
            state      <= ST_HALTED;
            ow_halted  <= 1'b1;
            ow_halt_pc <= iw_pc;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule : stg_wb
`default_nettype wire
